pe_op_sequencer: RTL
====================

// Module: pe_op_sequencer
// PURPOSE
//  Command-driven controller that sequences one pe_unit over a vector op.
//  Mode 00 MAC: dot product, one Q16.16 result. 01 EWM / 10 EWA: one result per element.
//  - Pulls Q8.8 operand pairs from a stream and issues them to the PE.
//  - For MAC, feeds the running accumulator back to the PE's acc port.
//  - Returns results on a ready/valid stream.
// PARAMETERS
//  DATA_WIDTH  16  operand width (Q8.8)
//  ACC_WIDTH   32  PE result / accumulator width (Q16.16)
//  LEN_W       10  width of cmd_len; max vector length 2**LEN_W-1
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           reset, asynchronous, active-low
//  abort        in   1           synchronous flush back to IDLE
//  cmd_valid    in   1           command handshake
//  cmd_ready    out  1           high only in IDLE
//  cmd_mode     in   2           00 MAC, 01 EWM, 10 EWA, 11 illegal
//  cmd_len      in   LEN_W       number of operand pairs
//  op_valid     in   1           operand stream handshake
//  op_ready     out  1
//  op_a, op_b   in   DATA_WIDTH  signed Q8.8 operands
//  pe_valid     out  1           PE valid_in
//  pe_mode      out  2           PE mode (latched cmd_mode)
//  pe_a, pe_b   out  DATA_WIDTH  forwarded operands
//  pe_acc       out  ACC_WIDTH   PE acc_in
//  pe_result    in   ACC_WIDTH   PE result_out (1-cycle latency)
//  pe_vout      in   1           PE valid_out
//  res_valid    out  1           result stream handshake
//  res_ready    in   1
//  res_data     out  ACC_WIDTH   Q16.16 result
//  res_last     out  1           final result of the command
//  busy         out  1           state != IDLE or result FIFO non-empty
//  err          out  1           1-cycle pulse on illegal command
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except cmd_ready=1. acc_q=0, counters 0, FIFO empty.
//  States: IDLE -> ISSUE -> DRAIN -> IDLE.
//  - IDLE: a cmd handshake latches mode/len, clears acc_q and issue/return counters.
//  - Illegal command (mode==11 or len==0): still accepted, err pulses next cycle,
//    nothing issued, stay in IDLE.
//  - ISSUE: op_ready = credit_ok. Issue happens when op_valid && op_ready.
//    On issue: pe_valid=1, pe_a/pe_b = op_a/op_b combinationally.
//    After issue #len, go to DRAIN.
//  - DRAIN: op_ready=0. On pe_vout for the last element, push the final result
//    and go to IDLE.
//  Credit rule (no result may be lost to backpressure):
//  - credit_ok = fifo_count + inflight < 2. inflight = 1 while a PE op is outstanding.
//  - MAC pushes only its final result, so credit_ok=1 for every MAC issue
//    except the last, which needs FIFO space.
//  MAC accumulator (back-to-back issue at 1/cycle):
//  - pe_acc = pe_vout ? pe_result : acc_q.
//  - acc_q <= pe_result on each pe_vout.
//  - Operand bubbles (op_valid=0) hold acc_q. Wraps two's complement, no saturation.
//  EWM/EWA: every pe_vout pushes pe_result. res_last set on the len-th push.
//  Result FIFO: 2 entries, first-word fall-through. res_valid = !empty.
//  - Push and pop in the same cycle are both legal when full.
//  pe_mode holds the latched mode through DRAIN.
//  abort (any state):
//  - Next cycle: IDLE, FIFO flushed, acc_q=0.
//  - A result returning from the PE in that cycle is dropped. No err.
//  - abort and cmd_valid together: abort wins, command not accepted.
//  Latency:
//  - EWM/EWA element: issue edge -> res_valid 1 cycle later (FIFO empty).
//  - MAC: res_valid 1 cycle after the last issue.
// STRUCTURE
//  pe_pkg: typedef enum logic[1:0] pe_mode_e {PE_MAC=2'b00, PE_EWM=2'b01, PE_EWA=2'b10};
//   typedef enum seq_state_e {S_IDLE, S_ISSUE, S_DRAIN}; DATA_WIDTH/ACC_WIDTH defaults.
//  Sub-module pe_res_fifo: 2-deep FWFT FIFO, ACC_WIDTH+1 wide (data+last), with count.
//  pe_unit is instantiated by the parent, not inside this block.
// TESTING (bench pairs this block with a pe_unit model)
//  1. MAC len=4, a=0x0100 b=0x0200, op_valid always 1:
//     - 4 consecutive issues; one result 0x0008_0000, res_last=1.
//  2. MAC len=3, op_valid gaps of 2 cycles between pairs, a=b=0x0100:
//     - result 0x0003_0000; acc_q unchanged during gaps.
//  3. EWA len=2, (0x0180,0x0080), (0xFF00,0x0100):
//     - results 0x0002_0000 then 0x0000_0000 (last=1).
//  4. EWM len=5 with res_ready=0:
//     - exactly 2 issues, op_ready stays 0.
//     - Raise res_ready: all 5 results in order, none lost.
//  5. cmd_mode=11 len=3, then cmd_len=0:
//     - err pulses each time, pe_valid never 1, cmd_ready back to 1.
//  6. abort in mid-ISSUE of EWM len=8, then reset mid-MAC:
//     - FIFO empty, IDLE next cycle, no res_valid.
//     - Next MAC len=1 (0x0100,0x0100) gives 0x0001_0000.

Source files
------------

// File: rtl/pe_op_sequencer_pkg.sv
// pe_op_sequencer_pkg: shared types and default widths for the PE op
// sequencer slice (PE operation modes, sequencer states, command legality).
package pe_op_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int LEN_W_DEF      = 10;

  typedef enum logic [1:0] {
    PE_MAC = 2'b00,
    PE_EWM = 2'b01,
    PE_EWA = 2'b10
  } pe_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } seq_state_e;

  // Mode 2'b11 has no PE operation behind it.
  function automatic logic mode_is_legal(input logic [1:0] mode);
    return mode != 2'b11;
  endfunction

endpackage

// File: rtl/pe_op_sequencer_if.sv
// pe_op_sequencer_if: command, operand, PE and result streams of the
// sequencer bundled together. The master side is the surrounding system
// (command source, operand source, pe_unit, result sink); the slave side is
// the sequencer itself.
interface pe_op_sequencer_if
  import pe_op_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_mode;
  logic [LEN_W-1:0]      cmd_len;

  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  logic                  pe_valid;
  logic [1:0]            pe_mode;
  logic [DATA_WIDTH-1:0] pe_a;
  logic [DATA_WIDTH-1:0] pe_b;
  logic [ACC_WIDTH-1:0]  pe_acc;
  logic [ACC_WIDTH-1:0]  pe_result;
  logic                  pe_vout;

  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic                  res_last;

  modport master (
    output cmd_valid, cmd_mode, cmd_len,
    output op_valid, op_a, op_b,
    output pe_result, pe_vout,
    output res_ready,
    input  cmd_ready, op_ready,
    input  pe_valid, pe_mode, pe_a, pe_b, pe_acc,
    input  res_valid, res_data, res_last
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_len,
    input  op_valid, op_a, op_b,
    input  pe_result, pe_vout,
    input  res_ready,
    output cmd_ready, op_ready,
    output pe_valid, pe_mode, pe_a, pe_b, pe_acc,
    output res_valid, res_data, res_last
  );

endinterface

// File: rtl/pe_op_sequencer_res_fifo.sv
// pe_res_fifo: 2-entry first-word-fall-through result FIFO with occupancy
// count. The head entry is visible on pop_data whenever empty is low.
// Push and pop may coincide even when full, since the pop frees the slot the
// push lands in. flush empties the FIFO synchronously.
module pe_res_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count_q != 2'd0);
  assign do_push  = push && ((count_q != 2'd2) || do_pop);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; flush drops everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pe_op_sequencer.sv
// pe_op_sequencer: command-driven controller that walks one external pe_unit
// over a vector op. MAC produces a single Q16.16 dot product; EWM/EWA produce
// one result per element. Operand pairs are pulled from a ready/valid stream,
// forwarded to the PE, and results come back through a 2-entry FIFO.
// Operands are only accepted when the FIFO is guaranteed to have room for the
// result they will produce, so result backpressure never loses data.
module pe_op_sequencer
  import pe_op_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  pe_op_sequencer_if.slave bus,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_ISSUE = S_ISSUE;
  localparam logic [1:0] ST_DRAIN = S_DRAIN;

  logic [1:0]           state_q;
  logic [1:0]           mode_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     issue_cnt_q;
  logic [LEN_W-1:0]     ret_cnt_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 inflight_q;
  logic                 err_q;

  logic                 cmd_accept;
  logic                 cmd_illegal;
  logic                 last_issue;
  logic                 last_ret;
  logic [2:0]           occupancy;
  logic                 credit_ok;
  logic                 issue;
  logic                 ret_valid;

  logic                 fifo_push;
  logic [ACC_WIDTH:0]   fifo_push_data;
  logic                 fifo_pop;
  logic [ACC_WIDTH:0]   fifo_pop_data;
  logic                 fifo_empty;
  logic [1:0]           fifo_count;

  // Command acceptance: only in IDLE, and abort always takes precedence.
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign cmd_accept    = bus.cmd_valid && (state_q == ST_IDLE) && !abort;
  assign cmd_illegal   = !mode_is_legal(bus.cmd_mode) || (bus.cmd_len == '0);

  assign last_issue = (issue_cnt_q == len_q - LEN_W'(1));
  assign last_ret   = (ret_cnt_q == len_q - LEN_W'(1));

  // A result-producing issue needs a FIFO slot not already claimed by a
  // stored result or by the op still in the PE. Intermediate MAC issues
  // never push, so only the final MAC issue is gated.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok = ((mode_q == PE_MAC) && !last_issue) || (occupancy < 3'd2);

  // Operands are held off during abort so no pair is consumed and then flushed.
  assign bus.op_ready = (state_q == ST_ISSUE) && credit_ok && !abort;
  assign issue        = bus.op_ready && bus.op_valid;

  assign bus.pe_valid = issue;
  assign bus.pe_mode  = mode_q;
  assign bus.pe_a     = issue ? bus.op_a : '0;
  assign bus.pe_b     = issue ? bus.op_b : '0;
  assign bus.pe_acc   = bus.pe_vout ? bus.pe_result : acc_q;

  // A returning PE result is dropped when it coincides with abort.
  assign ret_valid      = bus.pe_vout && (state_q != ST_IDLE) && !abort;
  assign fifo_push      = ret_valid && ((mode_q != PE_MAC) || last_ret);
  assign fifo_push_data = {last_ret, bus.pe_result};
  assign fifo_pop       = bus.res_ready && !fifo_empty;

  assign bus.res_valid = !fifo_empty;
  assign bus.res_data  = fifo_pop_data[ACC_WIDTH-1:0];
  assign bus.res_last  = fifo_pop_data[ACC_WIDTH];

  assign busy = (state_q != ST_IDLE) || !fifo_empty;
  assign err  = err_q;

  pe_res_fifo #(
    .WIDTH (ACC_WIDTH + 1)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sequencer FSM with command latch, issue/return counters and MAC accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'b00;
      len_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      acc_q       <= '0;
      inflight_q  <= 1'b0;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      acc_q       <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (ret_valid) begin
        ret_cnt_q <= ret_cnt_q + LEN_W'(1);
      end
      if (ret_valid && (mode_q == PE_MAC)) begin
        acc_q <= bus.pe_result;
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_accept && !cmd_illegal) begin
            mode_q      <= bus.cmd_mode;
            len_q       <= bus.cmd_len;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            acc_q       <= '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + LEN_W'(1);
            if (last_issue) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (ret_valid && last_ret) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // One-cycle error pulse for an accepted illegal command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cmd_accept && cmd_illegal;
    end
  end

endmodule
